// File: rtl/silife_gen_ctrl.sv
// Generation scheduler for the silife grid: free-run at a programmed period or single-step; arbitrates host writes vs generations.
// Latency: grid_start one cycle after the request is taken; gen_tick/gen_count one cycle after grid_done; wr_grant one cycle after wr_req is taken.
// Backpressure: host writes are held off (wr_grant=0) for the whole of a generation; the generation itself waits indefinitely for grid_done.
module silife_gen_ctrl #(
  parameter int PERIOD_W = 16,
  parameter int GEN_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clr_gen,
  input  logic                wr_req,
  output logic                wr_grant,
  output logic                grid_start,
  input  logic                grid_done,
  output logic                gen_tick,
  output logic [GEN_W-1:0]    gen_count,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GEN  = 2'd2,
    S_HOST = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  state_t              ret;
  state_t              ret_nxt;
  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] timer_nxt;
  logic                step_pend;
  logic                step_take;
  logic                done_acc;

  // A grid_done only counts while a generation is actually in flight.
  assign done_acc = (state == S_GEN) && grid_done;

  // Next-state decode: host access first, then pending step, then free-run.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret;
    timer_nxt = timer;
    step_take = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (wr_req) begin
          state_nxt = S_HOST;
          ret_nxt   = S_IDLE;
        end else if (step_pend) begin
          state_nxt = S_GEN;
          step_take = 1'b1;
        end else if (run) begin
          state_nxt = S_WAIT;
          timer_nxt = period;
        end
      end
      S_WAIT: begin
        // Timer is left untouched on the way to HOST so WAIT resumes where it paused.
        if (wr_req) begin
          state_nxt = S_HOST;
          ret_nxt   = S_WAIT;
        end else if (!run) begin
          state_nxt = S_IDLE;
        end else if (timer == '0) begin
          state_nxt = S_GEN;
        end else begin
          timer_nxt = timer - PERIOD_W'(1);
        end
      end
      S_GEN: begin
        // Nothing aborts a generation; only grid_done releases it.
        if (grid_done) begin
          if (wr_req) begin
            state_nxt = S_HOST;
            ret_nxt   = S_IDLE;
          end else if (step_pend) begin
            state_nxt = S_IDLE;
          end else if (run) begin
            state_nxt = S_WAIT;
            timer_nxt = period;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_HOST: begin
        if (!wr_req) begin
          state_nxt = ret;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state plus registered outputs, all derived from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ret        <= S_IDLE;
      timer      <= '0;
      wr_grant   <= 1'b0;
      grid_start <= 1'b0;
      gen_tick   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ret        <= ret_nxt;
      timer      <= timer_nxt;
      wr_grant   <= (state_nxt == S_HOST);
      grid_start <= (state_nxt == S_GEN) && (state != S_GEN);
      gen_tick   <= done_acc;
      busy       <= (state_nxt == S_GEN);
    end
  end

  // Pending single-step request; a step arriving as one is consumed still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_pend <= 1'b0;
    end else if (step && !run) begin
      step_pend <= 1'b1;
    end else if (step_take) begin
      step_pend <= 1'b0;
    end
  end

  // Completed-generation counter; clear wins over a same-cycle completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_count <= '0;
    end else if (clr_gen) begin
      gen_count <= '0;
    end else if (done_acc) begin
      gen_count <= gen_count + GEN_W'(1);
    end
  end

endmodule

// File: tb/tb_silife_gen_ctrl.sv
// Bench for silife_gen_ctrl: cycle table for the step path, then scoreboarded free-run/host/step/reset sequences.
// Latency: outputs sampled on the falling edge; inputs driven just after sampling.
// Backpressure: a behavioural grid answers grid_start after done_lat cycles when enabled.
module tb_silife_gen_ctrl;

  logic        clk = 1'b0;
  logic        reset, run, step, clr_gen, wr_req, grid_done;
  logic [15:0] period;
  logic        wr_grant, grid_start, gen_tick, busy;
  logic [15:0] gen_count;
  logic        wr_grant_w, grid_start_w, gen_tick_w, busy_w;
  logic [2:0]  gen_count_w;

  silife_gen_ctrl #(.PERIOD_W(16), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .period(period),
    .clr_gen(clr_gen), .wr_req(wr_req), .wr_grant(wr_grant),
    .grid_start(grid_start), .grid_done(grid_done), .gen_tick(gen_tick),
    .gen_count(gen_count), .busy(busy)
  );

  // Narrow counter copy, driven identically, so counter wrap is reachable quickly.
  silife_gen_ctrl #(.PERIOD_W(16), .GEN_W(3)) dut_w (
    .clk(clk), .reset(reset), .run(run), .step(step), .period(period),
    .clr_gen(clr_gen), .wr_req(wr_req), .wr_grant(wr_grant_w),
    .grid_start(grid_start_w), .grid_done(grid_done), .gen_tick(gen_tick_w),
    .gen_count(gen_count_w), .busy(busy_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, s, w, c, d;
    logic e_grant, e_start, e_tick, e_busy;
    int   e_cnt;
  } vec_t;

  typedef struct {
    int cyc;
    int cnt;
  } tk_t;

  vec_t tbl[$];
  int   start_q[$];
  tk_t  tick_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int n_tick = 0;
  int model_cnt = 0;
  int done_cnt = 0;
  int done_lat = 2;
  bit auto_grid = 1'b0;
  bit sb_en = 1'b0;
  int s0, t0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mv(input logic r, s, w, c, d, input logic g, st, tk, b, input int cnt);
    vec_t v;
    v.r = r; v.s = s; v.w = w; v.c = c; v.d = d;
    v.e_grant = g; v.e_start = st; v.e_tick = tk; v.e_busy = b; v.e_cnt = cnt;
    return v;
  endfunction

  // One cycle: sample at the falling edge, score events, then advance the grid model.
  task automatic tick();
    tk_t e;
    @(negedge clk);
    cyc++;
    if (sb_en && grid_start) begin
      n_start++;
      if (start_q.size() > 0) chk("start_cycle", cyc, start_q.pop_front());
      else chk("start_unexpected", grid_start, 0);
    end
    if (sb_en && gen_tick) begin
      n_tick++;
      if (tick_q.size() > 0) begin
        e = tick_q.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("tick_count", gen_count, e.cnt % 65536);
        chk("tick_count_w", gen_count_w, e.cnt % 8);
      end else begin
        chk("tick_unexpected", gen_tick, 0);
      end
    end
    if (auto_grid) begin
      if (done_cnt > 0) begin
        done_cnt--;
        grid_done = (done_cnt == 0);
      end else begin
        grid_done = 1'b0;
      end
      if (grid_start) done_cnt = done_lat;
      if (grid_done) begin
        model_cnt = model_cnt + 1;
        tick_q.push_back('{cyc + 1, model_cnt});
      end
    end
  endtask

  task automatic wait_ticks(input string name, input int target, input int budget);
    t0 = n_tick;
    for (int k = 0; k < budget && (n_tick - t0) < target; k++) tick();
    chk(name, n_tick - t0, target);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; clr_gen = 1'b0; wr_req = 1'b0;
    grid_done = 1'b0; period = 16'd0;

    // Step path, cycle by cycle: step at row 5, done 3 cycles after start.
    //            r  s  w  c  d   grant start tick busy cnt
    for (int i = 0; i < 5; i++) tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));  // 5
    tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // 6
    tbl.push_back(mv(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));  // 7
    tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));  // 8
    tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));  // 9
    tbl.push_back(mv(0, 0, 0, 0, 1, 0, 0, 0, 1, 0));  // 10
    tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));  // 11
    tbl.push_back(mv(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));  // 12
    tbl.push_back(mv(0, 0, 1, 0, 0, 1, 0, 0, 0, 1));  // 13
    tbl.push_back(mv(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));  // 14
    tbl.push_back(mv(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));  // 15
    tbl.push_back(mv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));  // 16: done outside GEN
    tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // 17

    repeat (2) @(negedge clk);
    chk("rst_grant", wr_grant, 0);
    chk("rst_start", grid_start, 0);
    chk("rst_tick", gen_tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", gen_count, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      tick();
      chk($sformatf("tbl%0d_grant", i), wr_grant, tbl[i].e_grant);
      chk($sformatf("tbl%0d_start", i), grid_start, tbl[i].e_start);
      chk($sformatf("tbl%0d_tick", i), gen_tick, tbl[i].e_tick);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_count", i), gen_count, tbl[i].e_cnt);
      run = tbl[i].r; step = tbl[i].s; wr_req = tbl[i].w;
      clr_gen = tbl[i].c; grid_done = tbl[i].d;
    end

    // Free-run, period 4, done latency 2: starts 8 cycles apart.
    sb_en = 1'b1; auto_grid = 1'b1; done_lat = 2; model_cnt = 0;
    tick(); period = 16'd4; run = 1'b1;
    for (int k = 0; k < 5; k++) start_q.push_back(cyc + 6 + 8 * k);
    wait_ticks("runA_ticks", 5, 200);
    run = 1'b0;
    chk("runA_count", gen_count, 5);
    repeat (4) tick();
    chk("runA_idle_busy", busy, 0);

    // Free-run, period 0: starts every done_lat+2 cycles; narrow counter wraps.
    tick(); period = 16'd0; run = 1'b1;
    for (int k = 0; k < 6; k++) start_q.push_back(cyc + 2 + 4 * k);
    wait_ticks("runB_ticks", 6, 200);
    run = 1'b0;
    chk("runB_count", gen_count, 11);
    chk("runB_wrap_w", gen_count_w, 3);
    repeat (4) tick();

    // Host request during GEN is held off until the generation completes.
    done_lat = 3;
    tick(); step = 1'b1; start_q.push_back(cyc + 2);
    tick(); step = 1'b0;
    tick(); chk("hostC_busy", busy, 1);
    tick(); chk("hostC_grant_gen0", wr_grant, 0); wr_req = 1'b1;
    tick(); chk("hostC_grant_gen1", wr_grant, 0);
    tick(); chk("hostC_grant_gen2", wr_grant, 0);
    tick(); chk("hostC_grant_after", wr_grant, 1); chk("hostC_tick", gen_tick, 1);
    tick(); chk("hostC_grant_hold1", wr_grant, 1);
    tick(); chk("hostC_grant_hold2", wr_grant, 1); wr_req = 1'b0;
    tick(); chk("hostC_grant_off", wr_grant, 0); chk("hostC_busy_off", busy, 0);
    repeat (3) tick();

    // Host request in WAIT with timer=2: WAIT resumes at 2 afterwards.
    done_lat = 2;
    tick(); period = 16'd5; run = 1'b1; start_q.push_back(cyc + 11);
    repeat (3) tick();
    tick(); chk("hostD_grant_wait", wr_grant, 0); wr_req = 1'b1;
    tick(); chk("hostD_grant1", wr_grant, 1);
    tick(); chk("hostD_grant2", wr_grant, 1);
    tick(); chk("hostD_grant3", wr_grant, 1); wr_req = 1'b0;
    tick(); chk("hostD_grant_off", wr_grant, 0); chk("hostD_busy", busy, 0);
    wait_ticks("hostD_ticks", 1, 40);
    run = 1'b0;
    chk("hostD_start_q", start_q.size(), 0);
    repeat (3) tick();

    // Step while running is dropped.
    s0 = n_start;
    tick(); period = 16'd20; run = 1'b1;
    tick(); tick(); step = 1'b1;
    tick(); step = 1'b0;
    tick(); tick(); run = 1'b0;
    repeat (8) tick();
    chk("stepRun_starts", n_start - s0, 0);

    // Step during GEN with run low: exactly two generations.
    s0 = n_start;
    tick(); step = 1'b1; start_q.push_back(cyc + 2); start_q.push_back(cyc + 6);
    tick(); step = 1'b0;
    tick();
    tick(); step = 1'b1;
    tick(); step = 1'b0;
    repeat (12) tick();
    chk("stepGen_starts", n_start - s0, 2);
    chk("stepGen_count", gen_count, 15);

    // Reset asserted mid-GEN clears everything at once; no start re-issued.
    tick(); step = 1'b1; start_q.push_back(cyc + 2);
    tick(); step = 1'b0;
    tick();
    tick(); chk("rstF_busy_pre", busy, 1);
    auto_grid = 1'b0; done_cnt = 0; grid_done = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstF_busy", busy, 0);
    chk("rstF_start", grid_start, 0);
    chk("rstF_grant", wr_grant, 0);
    chk("rstF_tick", gen_tick, 0);
    chk("rstF_count", gen_count, 0);
    model_cnt = 0;
    tick(); tick(); reset = 1'b0;
    s0 = n_start;
    repeat (8) tick();
    chk("rstF_no_restart", n_start - s0, 0);

    // clr_gen together with grid_done leaves the counter at zero.
    tick(); step = 1'b1; start_q.push_back(cyc + 2);
    tick(); step = 1'b0;
    tick();
    tick(); grid_done = 1'b1; tick_q.push_back('{cyc + 1, 1});
    tick(); grid_done = 1'b0;
    tick(); step = 1'b1; start_q.push_back(cyc + 2);
    tick(); step = 1'b0;
    tick();
    tick(); grid_done = 1'b1; clr_gen = 1'b1; tick_q.push_back('{cyc + 1, 0});
    tick(); grid_done = 1'b0; clr_gen = 1'b0;
    tick(); chk("clrG_count", gen_count, 0); chk("clrG_count_w", gen_count_w, 0);

    chk("tick_q_drained", tick_q.size(), 0);
    chk("start_q_drained", start_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
